// File: rtl/tdp_bram_pipe.sv
// rtl/tdp_bram_pipe.sv - true dual-port block RAM with lane writes, read pipeline and collision tracking
module tdp_bram_pipe #(
    parameter int WIDTH        = 72,
    parameter int DEPTH        = 512,
    parameter int LOG_DEPTH    = 9,
    parameter int LANE_W       = 9,
    parameter int RD_MODE_A    = 1,
    parameter int RD_MODE_B    = 1,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_en,
    input  logic [WIDTH/LANE_W-1:0] a_we,
    input  logic [LOG_DEPTH-1:0]    a_addr,
    input  logic [WIDTH-1:0]        a_wdata,
    output logic [WIDTH-1:0]        a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_en,
    input  logic [WIDTH/LANE_W-1:0] b_we,
    input  logic [LOG_DEPTH-1:0]    b_addr,
    input  logic [WIDTH-1:0]        b_wdata,
    output logic [WIDTH-1:0]        b_rdata,
    output logic                    b_rvalid,
    output logic                    collision,
    output logic [15:0]             coll_cnt
);
    localparam int NLANE = WIDTH / LANE_W;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LOG_DEPTH:0] DEPTH_L = (LOG_DEPTH + 1)'(DEPTH);

    if (LANE_W < 1 || (WIDTH % LANE_W) != 0) begin : g_bad_lane
        $error("tdp_bram_pipe: WIDTH must be a non-zero multiple of LANE_W");
    end
    if (RD_MODE_A < 0 || RD_MODE_A > 2 || RD_MODE_B < 0 || RD_MODE_B > 2) begin : g_bad_mode
        $error("tdp_bram_pipe: RD_MODE_A/RD_MODE_B must be 0, 1 or 2");
    end
    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_lat
        $error("tdp_bram_pipe: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 1 || DEPTH > (1 << LOG_DEPTH)) begin : g_bad_depth
        $error("tdp_bram_pipe: DEPTH must fit in LOG_DEPTH address bits");
    end

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    a_idx, b_idx;
    logic             a_in, b_in, a_wr, b_wr, same, coll_d;
    logic [WIDTH-1:0] a_old, b_old, a_final, b_final, a_ret, b_ret;
    logic             a_ret_v, b_ret_v;
    logic             a_v1, b_v1, a_v2, b_v2;
    logic [WIDTH-1:0] a_d1, b_d1, a_d2, b_d2;

    always_comb begin
        a_idx   = a_addr[AW-1:0];
        b_idx   = b_addr[AW-1:0];
        a_in    = {1'b0, a_addr} < DEPTH_L;
        b_in    = {1'b0, b_addr} < DEPTH_L;
        a_old   = a_in ? mem[a_idx] : '0;
        b_old   = b_in ? mem[b_idx] : '0;
        a_wr    = a_en && (a_we != '0);
        b_wr    = b_en && (b_we != '0);
        same    = a_en && b_en && a_in && (a_addr == b_addr);
        coll_d  = same && (a_wr || b_wr);
        a_final = a_old;
        b_final = b_old;
        // Both ports build the same final word on a shared address; port A wins shared lanes.
        for (int l = 0; l < NLANE; l++) begin
            if (a_we[l])
                a_final[l*LANE_W +: LANE_W] = a_wdata[l*LANE_W +: LANE_W];
            else if (same && b_we[l])
                a_final[l*LANE_W +: LANE_W] = b_wdata[l*LANE_W +: LANE_W];
            if (same && a_we[l])
                b_final[l*LANE_W +: LANE_W] = a_wdata[l*LANE_W +: LANE_W];
            else if (b_we[l])
                b_final[l*LANE_W +: LANE_W] = b_wdata[l*LANE_W +: LANE_W];
        end
        a_ret_v = a_en && (!a_wr || RD_MODE_A != 0);
        b_ret_v = b_en && (!b_wr || RD_MODE_B != 0);
        a_ret   = (a_wr && RD_MODE_A == 2) ? a_final : a_old;
        b_ret   = (b_wr && RD_MODE_B == 2) ? b_final : b_old;
    end

    // The array is never reset; clocking it under rst_n only gates writes during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_v1      <= 1'b0;
            b_v1      <= 1'b0;
            a_v2      <= 1'b0;
            b_v2      <= 1'b0;
            a_d1      <= '0;
            b_d1      <= '0;
            a_d2      <= '0;
            b_d2      <= '0;
            collision <= 1'b0;
            coll_cnt  <= '0;
        end else begin
            if (a_wr && a_in) mem[a_idx] <= a_final;
            if (b_wr && b_in) mem[b_idx] <= b_final;
            a_v1 <= a_ret_v;
            b_v1 <= b_ret_v;
            if (a_ret_v) a_d1 <= a_ret;
            if (b_ret_v) b_d1 <= b_ret;
            a_v2 <= a_v1;
            b_v2 <= b_v1;
            if (a_v1) a_d2 <= a_d1;
            if (b_v1) b_d2 <= b_d1;
            collision <= coll_d;
            if (coll_d && coll_cnt != 16'hFFFF) coll_cnt <= coll_cnt + 16'd1;
        end
    end

    assign a_rdata  = (READ_LATENCY == 2) ? a_d2 : a_d1;
    assign b_rdata  = (READ_LATENCY == 2) ? b_d2 : b_d1;
    assign a_rvalid = (READ_LATENCY == 2) ? a_v2 : a_v1;
    assign b_rvalid = (READ_LATENCY == 2) ? b_v2 : b_v1;
endmodule

// File: tb/tb_tdp_bram_pipe.sv
// tb/tb_tdp_bram_pipe.sv - self-checking bench for tdp_bram_pipe
module tb_tdp_bram_pipe;
    localparam int W  = 72;
    localparam int NL = 8;
    localparam int AW = 10;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    typedef struct {
        bit            a_en;
        logic [NL-1:0] a_we;
        logic [AW-1:0] a_addr;
        logic [W-1:0]  a_wdata;
        bit            b_en;
        logic [NL-1:0] b_we;
        logic [AW-1:0] b_addr;
        logic [W-1:0]  b_wdata;
        bit            coll;
    } vec_t;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_en = 1'b0, b_en = 1'b0;
    logic [NL-1:0] a_we = '0, b_we = '0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [W-1:0]  a_wdata = '0, b_wdata = '0;
    logic [W-1:0]  a_rd [3];
    logic [W-1:0]  b_rd [3];
    logic          a_rv [3];
    logic          b_rv [3];
    logic          coll [3];
    logic [15:0]   cnt  [3];

    always #5 clk = ~clk;

    // Instance index equals its port-A read-during-write mode.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        tdp_bram_pipe #(
            .WIDTH(W), .DEPTH(512), .LOG_DEPTH(AW), .LANE_W(9),
            .RD_MODE_A(g), .RD_MODE_B(1), .READ_LATENCY(g == 1 ? 1 : 2)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
            .a_rdata(a_rd[g]), .a_rvalid(a_rv[g]),
            .b_en(b_en), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
            .b_rdata(b_rd[g]), .b_rvalid(b_rv[g]),
            .collision(coll[g]), .coll_cnt(cnt[g])
        );
    end

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc_cnt = 0;
    int           m_cnt = 0;
    int           rvb0 = 0;
    logic [W-1:0] mm [512];
    exp_t         qa [3][$];
    exp_t         qb [3][$];
    vec_t         vecs [19];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int lat_of(input int d);
        return (d == 1) ? 1 : 2;
    endfunction

    function automatic logic [W-1:0] rd_m(input logic [AW-1:0] ad);
        return (ad < 10'd512) ? mm[ad[8:0]] : '0;
    endfunction

    function automatic logic [W-1:0] lanes(input logic [W-1:0] base, input logic [W-1:0] nd,
                                           input logic [NL-1:0] we);
        logic [W-1:0] r;
        r = base;
        for (int i = 0; i < NL; i++)
            if (we[i]) r[i*9 +: 9] = nd[i*9 +: 9];
        return r;
    endfunction

    function automatic vec_t mk(input bit ae, input logic [NL-1:0] awe, input int aad,
                                input logic [W-1:0] awd, input bit be, input logic [NL-1:0] bwe,
                                input int bad, input logic [W-1:0] bwd, input bit c);
        vec_t v;
        v.a_en = ae; v.a_we = awe; v.a_addr = AW'(aad); v.a_wdata = awd;
        v.b_en = be; v.b_we = bwe; v.b_addr = AW'(bad); v.b_wdata = bwd;
        v.coll = c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic mon(input int d, input bit pb);
        exp_t  e;
        logic  v;
        logic [W-1:0] r;
        int    sz;
        string nm;
        v  = pb ? b_rv[d] : a_rv[d];
        r  = pb ? b_rd[d] : a_rd[d];
        sz = pb ? qb[d].size() : qa[d].size();
        nm = $sformatf("%s_d%0d", pb ? "b" : "a", d);
        if (v === 1'b1) begin
            if (sz == 0) begin
                chk({nm, "_spurious_rvalid"}, 72'd1, 72'd0);
            end else begin
                if (pb) e = qb[d].pop_front();
                else    e = qa[d].pop_front();
                chk({nm, "_rdata"}, r, e.data);
                chk({nm, "_latency"}, 72'(cyc_cnt), 72'(e.due));
            end
        end else if (sz != 0) begin
            if (pb) e = qb[d][0];
            else    e = qa[d][0];
            if (e.due <= cyc_cnt) begin
                chk({nm, "_missing_rvalid"}, 72'd0, 72'd1);
                if (pb) void'(qb[d].pop_front());
                else    void'(qa[d].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            mon(d, 1'b0);
            mon(d, 1'b1);
        end
        if (b_rv[0] === 1'b1) rvb0++;
    end

    task automatic step(input vec_t v, input bit ck);
        logic [W-1:0] oa, ob, fa, fb;
        bit           same, aw, bw;
        exp_t         e;
        a_en = v.a_en; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata;
        b_en = v.b_en; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata;
        oa   = rd_m(v.a_addr);
        ob   = rd_m(v.b_addr);
        same = v.a_en && v.b_en && (v.a_addr == v.b_addr) && (v.a_addr < 10'd512);
        aw   = v.a_en && (v.a_we != '0);
        bw   = v.b_en && (v.b_we != '0);
        fa   = lanes(lanes(oa, v.b_wdata, same ? v.b_we : '0), v.a_wdata, v.a_we);
        fb   = lanes(lanes(ob, v.b_wdata, v.b_we), v.a_wdata, same ? v.a_we : '0);
        for (int d = 0; d < 3; d++) begin
            e.due = cyc_cnt + lat_of(d);
            if (v.a_en && !(aw && d == 0)) begin
                e.data = (aw && d == 2) ? fa : oa;
                qa[d].push_back(e);
            end
            if (v.b_en) begin
                e.data = ob;
                qb[d].push_back(e);
            end
        end
        @(posedge clk);
        #1;
        if (aw && v.a_addr < 10'd512) mm[v.a_addr[8:0]] = fa;
        if (bw && v.b_addr < 10'd512) mm[v.b_addr[8:0]] = fb;
        if (same && (aw || bw) && m_cnt < 65535) m_cnt++;
        if (ck) begin
            chk("collision", 72'(coll[1]), 72'(v.coll));
            chk("coll_cnt", 72'(cnt[1]), 72'(m_cnt));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(mk(0, '0, 0, '0, 0, '0, 0, '0, 0), 1'b1);
    endtask

    initial begin
        vecs[0]  = mk(1, 8'hFF, 5, 72'h0123456789ABCDEF01, 0, '0, 0, '0, 0);
        vecs[1]  = mk(0, '0, 0, '0, 1, '0, 5, '0, 0);
        vecs[2]  = mk(1, 8'hFF, 7, ONES, 0, '0, 0, '0, 0);
        vecs[3]  = mk(1, 8'h05, 7, '0, 0, '0, 0, '0, 0);
        vecs[4]  = mk(0, '0, 0, '0, 1, '0, 7, '0, 0);
        vecs[5]  = mk(1, 8'hFF, 3, 72'h11, 0, '0, 0, '0, 0);
        vecs[6]  = mk(1, 8'hFF, 3, 72'h22, 0, '0, 0, '0, 0);
        vecs[7]  = mk(1, '0, 3, '0, 0, '0, 0, '0, 0);
        vecs[8]  = mk(1, 8'hFF, 9, 72'hAA, 1, 8'hFF, 9, 72'hBB, 1);
        vecs[9]  = mk(0, '0, 0, '0, 1, '0, 9, '0, 0);
        vecs[10] = mk(1, 8'hFF, 9, 72'hCC, 1, '0, 9, '0, 1);
        vecs[11] = mk(0, '0, 0, '0, 1, '0, 9, '0, 0);
        vecs[12] = mk(1, 8'h0F, 9, ONES, 1, 8'h3C, 9, '0, 1);
        vecs[13] = mk(1, '0, 9, '0, 1, '0, 9, '0, 0);
        vecs[14] = mk(1, 8'hFF, 88, 72'h5A, 0, '0, 0, '0, 0);
        vecs[15] = mk(1, '0, 600, '0, 1, 8'hFF, 600, ONES, 0);
        vecs[16] = mk(1, '0, 600, '0, 1, '0, 88, '0, 0);
        vecs[17] = mk(1, 8'hFF, 9, 72'hDD, 1, 8'hFF, 10, 72'hEE, 0);
        vecs[18] = mk(0, '0, 0, '0, 0, '0, 0, '0, 0);

        // Activity during reset must leave outputs at their reset values.
        a_en = 1'b1; a_we = 8'hFF; a_addr = 10'd5; a_wdata = ONES; b_en = 1'b1;
        #12;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_a_rdata_d%0d", d), a_rd[d], '0);
            chk($sformatf("rst_b_rvalid_d%0d", d), 72'(b_rv[d]), 72'd0);
            chk($sformatf("rst_coll_cnt_d%0d", d), 72'(cnt[d]), 72'd0);
        end
        a_en = 1'b0; b_en = 1'b0; a_we = '0;
        #5 rst_n = 1'b1;

        foreach (vecs[i]) step(vecs[i], 1'b1);
        idle(3);

        for (int i = 0; i < 64; i++)
            step(mk(1, 8'hFF, i, {8'(i), 64'hC0FFEE0000000000 | 64'(i * 3)}, 0, '0, 0, '0, 0), 1'b1);
        idle(3);
        rvb0 = 0;
        for (int i = 0; i < 64; i++) step(mk(0, '0, 0, '0, 1, '0, i, '0, 0), 1'b1);
        idle(3);
        chk("burst_rvalid_count", 72'(rvb0), 72'd64);

        for (int i = 0; i < 21; i++) step(mk(0, '0, 0, '0, 1, '0, i, '0, 0), 1'b1);
        #2;
        rst_n = 1'b0;
        a_en = 1'b1; a_we = 8'hFF; a_addr = 10'd0; a_wdata = ONES; b_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            qa[d].delete();
            qb[d].delete();
        end
        m_cnt = 0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("midrst_b_rvalid_d%0d", d), 72'(b_rv[d]), 72'd0);
            chk($sformatf("midrst_b_rdata_d%0d", d), b_rd[d], '0);
        end
        @(posedge clk);
        @(posedge clk);
        #4;
        rst_n = 1'b1;
        a_en = 1'b0; a_we = '0;
        idle(4);
        step(mk(0, '0, 0, '0, 1, '0, 0, '0, 0), 1'b1);
        idle(3);

        for (int n = 0; n < 65540; n++)
            step(mk(1, 8'hFF, 20, 72'(n), 1, 8'hFF, 20, ONES, 1), n >= 65538);
        idle(3);
        for (int d = 0; d < 3; d++)
            chk($sformatf("coll_cnt_sat_d%0d", d), 72'(cnt[d]), 72'hFFFF);

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("a_queue_drained_d%0d", d), 72'(qa[d].size()), 72'd0);
            chk($sformatf("b_queue_drained_d%0d", d), 72'(qb[d].size()), 72'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
